// File: rtl/conv_act_obuf.sv
// conv_act_obuf: captures a conv-layer accumulator vector, then streams it
// out one element per cycle with ReLU, rounding shift and saturation.
module conv_act_obuf #(
  parameter int output_size          = 512,
  parameter int output_datatype_size = 20,
  parameter int act_datatype_size    = 8,
  parameter int shift                = 4,
  parameter bit relu_en              = 1'b1,
  localparam int IW = (output_size > 1) ? $clog2(output_size) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic [output_size-1:0][output_datatype_size-1:0] i_data,
  output logic o_busy,
  output logic o_valid,
  input  logic i_ready,
  output logic [act_datatype_size-1:0] o_data,
  output logic [IW-1:0] o_idx,
  output logic o_last,
  output logic o_done
);

  localparam int W = output_datatype_size;
  localparam int A = act_datatype_size;
  localparam logic [IW-1:0] LAST = IW'(output_size - 1);
  localparam logic [IW-1:0] PENULT = IW'(output_size - 2);

  localparam int RSH = (shift > 0) ? shift - 1 : 0;
  localparam logic signed [W:0] RND =
    (shift > 0) ? ((W+1)'(1) << RSH) : '0;
  localparam logic signed [W:0] MAXV = (W+1)'((1 << (A-1)) - 1);
  localparam logic signed [W:0] MINV = ~MAXV;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  logic [output_size-1:0][W-1:0] vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      vec     <= '0;
      o_idx   <= '0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_start) begin
            vec     <= i_data;
            o_idx   <= '0;
            o_busy  <= 1'b1;
            o_valid <= 1'b1;
            o_last  <= (output_size == 1);
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (i_ready) begin
            if (o_idx == LAST) begin
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              o_done  <= 1'b1;
              state   <= DONE;
            end else begin
              o_idx  <= o_idx + 1'b1;
              o_last <= (o_idx == PENULT);
            end
          end
        end
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic signed [W-1:0] x;
  logic signed [W:0] xr;
  logic signed [W:0] sum;
  logic signed [W:0] y;

  // One extra bit keeps the rounding add from wrapping at full scale.
  always_comb begin
    x   = vec[o_idx];
    xr  = (relu_en && x[W-1]) ? '0 : {x[W-1], x};
    sum = xr + RND;
    y   = sum >>> shift;
    if (y > MAXV) begin
      o_data = MAXV[A-1:0];
    end else if (y < MINV) begin
      o_data = MINV[A-1:0];
    end else begin
      o_data = y[A-1:0];
    end
  end

endmodule

// File: tb/tb_conv_act_obuf.sv
// tb_conv_act_obuf: vector table plus scoreboard over three 4-element
// configurations and one single-element instance.
module tb_conv_act_obuf;

  localparam int N  = 4;
  localparam int DW = 20;
  localparam int AW = 8;
  localparam int SH [3] = '{4, 4, 0};
  localparam bit RE [3] = '{1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_start = 1'b0;
  logic i_ready = 1'b0;
  logic [N-1:0][DW-1:0] i_data = '0;
  logic [0:0][DW-1:0] i_data_d;

  logic busy [3];
  logic valid [3];
  logic last [3];
  logic done [3];
  logic [AW-1:0] data [3];
  logic [1:0] idx [3];

  logic busy_d, valid_d, last_d, done_d;
  logic [AW-1:0] data_d;
  logic [0:0] idx_d;

  assign i_data_d[0] = i_data[0];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    conv_act_obuf #(
      .output_size(N),
      .output_datatype_size(DW),
      .act_datatype_size(AW),
      .shift(SH[g]),
      .relu_en(RE[g])
    ) u (
      .clk(clk),
      .rst(rst),
      .i_start(i_start),
      .i_data(i_data),
      .o_busy(busy[g]),
      .o_valid(valid[g]),
      .i_ready(i_ready),
      .o_data(data[g]),
      .o_idx(idx[g]),
      .o_last(last[g]),
      .o_done(done[g])
    );
  end

  conv_act_obuf #(
    .output_size(1),
    .output_datatype_size(DW),
    .act_datatype_size(AW),
    .shift(4),
    .relu_en(1'b1)
  ) u_one (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .i_data(i_data_d),
    .o_busy(busy_d),
    .o_valid(valid_d),
    .i_ready(i_ready),
    .o_data(data_d),
    .o_idx(idx_d),
    .o_last(last_d),
    .o_done(done_d)
  );

  typedef struct {
    int x [4];
    int ea [4];
    int eb [4];
    int ec [4];
  } vec_t;

  typedef struct {
    int d [3];
    int i;
  } exp_t;

  vec_t tbl [5];
  exp_t qabc [$];
  int qd [$];
  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (valid[0]) begin
        if (qabc.size() == 0) begin
          chk("sb_abc_empty", 1, 0);
        end else begin
          for (int k = 0; k < 3; k++) begin
            chk($sformatf("valid%0d", k), int'(valid[k]), 1);
            chk($sformatf("data%0d", k), int'($signed(data[k])), qabc[0].d[k]);
            chk($sformatf("idx%0d", k), int'(idx[k]), qabc[0].i);
            chk($sformatf("last%0d", k), int'(last[k]),
                int'(qabc[0].i == N - 1));
          end
          if (i_ready) void'(qabc.pop_front());
        end
      end
      if (valid_d) begin
        if (qd.size() == 0) begin
          chk("sb_d_empty", 1, 0);
        end else begin
          chk("data_d", int'($signed(data_d)), qd[0]);
          chk("idx_d", int'(idx_d), 0);
          chk("last_d", int'(last_d), 1);
          if (i_ready) void'(qd.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int v);
    exp_t e;
    for (int j = 0; j < N; j++) begin
      e.d[0] = tbl[v].ea[j];
      e.d[1] = tbl[v].eb[j];
      e.d[2] = tbl[v].ec[j];
      e.i = j;
      qabc.push_back(e);
    end
    qd.push_back(tbl[v].ea[0]);
  endtask

  task automatic load(input int v);
    int t;
    for (int j = 0; j < N; j++) begin
      t = tbl[v].x[j];
      i_data[j] = t[DW-1:0];
    end
  endtask

  task automatic start(input int v);
    load(v);
    push_exp(v);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic run_vec(input int v);
    int c;
    i_ready = 1'b1;
    start(v);
    chk("valid_n1", int'(valid[0]), 1);
    chk("busy_n1", int'(busy[0]), 1);
    c = 0;
    while (!done[0] && c < 20) begin
      tick();
      c++;
    end
    chk("done_lat", c, N);
    chk("busy_in_done", int'(busy[0]), 1);
    tick();
    chk("done_pulse", int'(done[0]), 0);
    chk("busy_drop", int'(busy[0]), 0);
    chk("sb_drained", qabc.size(), 0);
  endtask

  initial begin
    int c;
    int pat [4];
    pat = '{1, 0, 0, 1};

    tbl[0].x  = '{100, -50, 5000, 8};
    tbl[0].ea = '{6, 0, 127, 1};
    tbl[0].eb = '{6, -3, 127, 1};
    tbl[0].ec = '{100, -50, 127, 8};
    tbl[1].x  = '{-50, -5000, -8, 0};
    tbl[1].ea = '{0, 0, 0, 0};
    tbl[1].eb = '{-3, -128, 0, 0};
    tbl[1].ec = '{-50, -128, -8, 0};
    tbl[2].x  = '{127, 128, -129, 3};
    tbl[2].ea = '{8, 8, 0, 0};
    tbl[2].eb = '{8, 8, -8, 0};
    tbl[2].ec = '{127, 127, -128, 3};
    tbl[3].x  = '{24, -24, 2024, -2072};
    tbl[3].ea = '{2, 0, 127, 0};
    tbl[3].eb = '{2, -1, 127, -128};
    tbl[3].ec = '{24, -24, 127, -128};
    tbl[4].x  = '{524287, -524288, 7, -9};
    tbl[4].ea = '{127, 0, 0, 0};
    tbl[4].eb = '{127, -128, 0, -1};
    tbl[4].ec = '{127, -128, 7, -9};

    #3;
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_valid", int'(valid[0]), 0);
    chk("rst_last", int'(last[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_idx", int'(idx[0]), 0);
    chk("rst_data", int'(data[0]), 0);
    chk("rst_valid_d", int'(valid_d), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) run_vec(v);

    start(0);
    c = 0;
    while (!done[0] && c < 40) begin
      i_ready = pat[c % 4][0];
      tick();
      c++;
    end
    chk("bp_cycles", c, 8);
    chk("bp_done", int'(done[0]), 1);
    chk("bp_sb_empty", qabc.size(), 0);
    i_ready = 1'b1;
    tick();

    start(1);
    tick();
    chk("d_done", int'(done_d), 1);
    load(2);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    c = 0;
    while (!done[0] && c < 20) begin
      chk("busy_hold", int'(busy[0]), 1);
      tick();
      c++;
    end
    chk("ign_done", int'(done[0]), 1);
    tick();
    chk("ign_sb_empty", qabc.size(), 0);
    chk("ign_d_empty", qd.size(), 0);
    chk("ign_d_idle", int'(busy_d), 0);

    start(2);
    c = 0;
    while (idx[0] != 2'd2 && c < 10) begin
      tick();
      c++;
    end
    chk("ar_reach_idx2", int'(idx[0]), 2);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", int'(valid[0]), 0);
    chk("ar_busy", int'(busy[0]), 0);
    chk("ar_data", int'(data[0]), 0);
    chk("ar_idx", int'(idx[0]), 0);
    qabc.delete();
    qd.delete();
    repeat (2) begin
      tick();
      chk("ar_no_done", int'(done[0]), 0);
    end
    rst = 1'b1;
    repeat (3) begin
      tick();
      chk("ar_idle_done", int'(done[0]), 0);
      chk("ar_idle_busy", int'(busy[0]), 0);
    end
    run_vec(3);

    chk("end_sb_empty", qabc.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
